// File: rtl/maxpool1d_layer.sv
// maxpool1d_layer
// Non-overlapping 1-D signed max pooling. A NUM_FILTERS-wide sample vector is taken on
// each handshake. A running maximum is kept per channel over POOL_SIZE samples. One
// pooled vector is emitted per window, so the stride equals POOL_SIZE.
// Optional feature: define MAXPOOL1D_RELU_EN to clamp negative samples to zero before
// the compare/load. Without it, the raw signed maximum is produced.
module maxpool1d_layer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_FILTERS = 32,
  parameter int POOL_SIZE   = 2,
  parameter int FRACTION    = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   maxpool1d_layer_ready_in,
  input  logic [NUM_FILTERS-1:0] maxpool1d_layer_valid_in,
  input  logic [DATA_WIDTH-1:0]  maxpool1d_layer_data_in [0:NUM_FILTERS-1],
  input  logic                   maxpool1d_layer_ready_out,
  output logic [NUM_FILTERS-1:0] maxpool1d_layer_valid_out,
  output logic [DATA_WIDTH-1:0]  maxpool1d_layer_data_out [0:NUM_FILTERS-1]
);

  localparam int COUNTER_WIDTH = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(POOL_SIZE - 1);

  // FRACTION only documents the fixed-point format. The compare is a raw signed compare.
  if (POOL_SIZE < 1) begin : g_bad_pool
    $error("maxpool1d_layer: POOL_SIZE must be >= 1");
  end
  if (FRACTION < 0 || FRACTION >= DATA_WIDTH) begin : g_bad_fraction
    $error("maxpool1d_layer: FRACTION must lie in [0, DATA_WIDTH)");
  end

  logic [COUNTER_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]    run [0:NUM_FILTERS-1];
  logic [DATA_WIDTH-1:0]    x   [0:NUM_FILTERS-1];
  logic                     out_full;
  logic                     accept;
  logic                     last;

  assign out_full                 = maxpool1d_layer_valid_out[0];
  assign maxpool1d_layer_ready_in = ~(out_full & ~maxpool1d_layer_ready_out);
  assign accept                   = maxpool1d_layer_ready_in & (&maxpool1d_layer_valid_in);
  assign last                     = (cnt == CNT_LAST);

  // Sample conditioning ahead of the compare (optional ReLU clamp)
  always_comb begin
    for (int c = 0; c < NUM_FILTERS; c++) begin
`ifdef MAXPOOL1D_RELU_EN
      x[c] = maxpool1d_layer_data_in[c][DATA_WIDTH-1] ? '0 : maxpool1d_layer_data_in[c];
`else
      x[c] = maxpool1d_layer_data_in[c];
`endif
    end
  end

  // Window position counter: advances on accept, wraps after the last sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      if (last) cnt <= '0;
      else      cnt <= cnt + COUNTER_WIDTH'(1);
    end
  end

  // Running maximum: the first sample loads directly, so a stale window never leaks in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_FILTERS; c++) run[c] <= '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_FILTERS; c++) begin
        if (cnt == '0)
          run[c] <= x[c];
        else if ($signed(x[c]) > $signed(run[c]))
          run[c] <= x[c];
      end
    end
  end

  // Output register: load on window close (even while draining), else clear valid on drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maxpool1d_layer_valid_out <= '0;
      for (int c = 0; c < NUM_FILTERS; c++) maxpool1d_layer_data_out[c] <= '0;
    end else if (accept && last) begin
      maxpool1d_layer_valid_out <= '1;
      for (int c = 0; c < NUM_FILTERS; c++) begin
        if (POOL_SIZE == 1)
          maxpool1d_layer_data_out[c] <= x[c];
        else
          maxpool1d_layer_data_out[c] <= ($signed(x[c]) > $signed(run[c])) ? x[c] : run[c];
      end
    end else if (out_full && maxpool1d_layer_ready_out) begin
      maxpool1d_layer_valid_out <= '0;
    end
  end

endmodule

// File: tb/tb_maxpool1d_layer.sv
// Testbench for maxpool1d_layer: POOL_SIZE=2 instance plus a POOL_SIZE=1 instance.
// Expected windows are pushed to a queue as samples are accepted and popped on each
// output handshake.
`timescale 1ns/1ps
module tb_maxpool1d_layer;
  localparam int DW = 32;
  localparam int NF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ready_in, ready_out;
  logic [NF-1:0] valid_in, valid_out;
  logic [DW-1:0] data_in  [0:NF-1];
  logic [DW-1:0] data_out [0:NF-1];

  logic          ready_in1, ready_out1;
  logic [NF-1:0] valid_in1, valid_out1;
  logic [DW-1:0] data_in1  [0:NF-1];
  logic [DW-1:0] data_out1 [0:NF-1];

  maxpool1d_layer #(.DATA_WIDTH(DW), .NUM_FILTERS(NF), .POOL_SIZE(2), .FRACTION(24)) dut (
    .clk(clk), .rst(rst),
    .maxpool1d_layer_ready_in(ready_in), .maxpool1d_layer_valid_in(valid_in),
    .maxpool1d_layer_data_in(data_in), .maxpool1d_layer_ready_out(ready_out),
    .maxpool1d_layer_valid_out(valid_out), .maxpool1d_layer_data_out(data_out));

  maxpool1d_layer #(.DATA_WIDTH(DW), .NUM_FILTERS(NF), .POOL_SIZE(1), .FRACTION(24)) dut1 (
    .clk(clk), .rst(rst),
    .maxpool1d_layer_ready_in(ready_in1), .maxpool1d_layer_valid_in(valid_in1),
    .maxpool1d_layer_data_in(data_in1), .maxpool1d_layer_ready_out(ready_out1),
    .maxpool1d_layer_valid_out(valid_out1), .maxpool1d_layer_data_out(data_out1));

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] q[$];
  logic [63:0] q1[$];
  logic [63:0] e_p2, e_p1;
  int          m_cnt = 0;
  logic [31:0] m_run [0:1];

`ifdef MAXPOOL1D_RELU_EN
  localparam logic [31:0] EXP_NEG = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_NEG = 32'hFF80_0000;
`endif

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef MAXPOOL1D_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] smax(input logic [31:0] a, input logic [31:0] b);
    return ($signed(b) > $signed(a)) ? b : a;
  endfunction

  // Scoreboard for the POOL_SIZE=2 instance
  always @(negedge clk) begin
    if (!rst && valid_out[0] && ready_out) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_p2_unexpected: got %h %h with nothing expected", data_out[1], data_out[0]);
      end else begin
        e_p2 = q.pop_front();
        if ({data_out[1], data_out[0]} !== e_p2 || valid_out !== 2'b11) begin
          n_bad++;
          $display("FAIL sb_p2_data: got %h %h valid %b, want %h %h valid 11",
                   data_out[1], data_out[0], valid_out, e_p2[63:32], e_p2[31:0]);
        end
      end
    end
  end

  // Scoreboard for the POOL_SIZE=1 instance
  always @(negedge clk) begin
    if (!rst && valid_out1[0] && ready_out1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL sb_p1_unexpected: got %h %h with nothing expected", data_out1[1], data_out1[0]);
      end else begin
        e_p1 = q1.pop_front();
        if ({data_out1[1], data_out1[0]} !== e_p1 || valid_out1 !== 2'b11) begin
          n_bad++;
          $display("FAIL sb_p1_data: got %h %h valid %b, want %h %h valid 11",
                   data_out1[1], data_out1[0], valid_out1, e_p1[63:32], e_p1[31:0]);
        end
      end
    end
  end

  // Offer one full vector to the POOL_SIZE=2 instance and wait (bounded) for acceptance.
  task automatic send(input logic [31:0] a0, input logic [31:0] a1, output int waits);
    int w;
    logic [31:0] x0, x1;
    w = 0;
    valid_in = 2'b11; data_in[0] = a0; data_in[1] = a1;
    @(negedge clk);
    while (!ready_in && w < 50) begin w++; @(negedge clk); end
    waits = w;
    if (!ready_in) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: ready_in=%b after %0d cycles, want 1", ready_in, w);
      valid_in = '0;
      return;
    end
    @(posedge clk);
    x0 = relu(a0); x1 = relu(a1);
    if (m_cnt == 0) begin
      m_run[0] = x0; m_run[1] = x1; m_cnt = 1;
    end else begin
      q.push_back({smax(m_run[1], x1), smax(m_run[0], x0)});
      m_cnt = 0;
    end
    #1;
    valid_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready_out = 1'b1; ready_out1 = 1'b1;
    valid_in = '0; valid_in1 = '0;
    for (int c = 0; c < NF; c++) begin data_in[c] = '0; data_in1[c] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (valid_out !== 2'b00) begin n_bad++; $display("FAIL reset_valid: got %b want 00", valid_out); end
    n_cmp++; if (data_out[0] !== 32'h0 || data_out[1] !== 32'h0) begin n_bad++;
      $display("FAIL reset_data: got %h %h want 0 0", data_out[1], data_out[0]); end
    n_cmp++; if (ready_in !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_in); end
    n_cmp++; if (valid_out1 !== 2'b00 || ready_in1 !== 1'b1) begin n_bad++;
      $display("FAIL reset_p1: got valid %b ready %b want 00 1", valid_out1, ready_in1); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int w;
    send(32'h0100_0000, 32'hFF00_0000, w);
    n_cmp++; if (valid_out !== 2'b00) begin n_bad++; $display("FAIL basic_early: got valid %b want 00", valid_out); end
    send(32'h0080_0000, 32'h0200_0000, w);
    n_cmp++; if (valid_out !== 2'b11 || data_out[0] !== 32'h0100_0000 || data_out[1] !== 32'h0200_0000) begin
      n_bad++; $display("FAIL basic_latency: got %b %h %h want 11 02000000 01000000", valid_out, data_out[1], data_out[0]); end
    @(posedge clk); #1;
    n_cmp++; if (valid_out !== 2'b00) begin n_bad++; $display("FAIL basic_one_cycle: got %b want 00", valid_out); end
  endtask

  task automatic test_negative();
    int w;
    send(32'hFF00_0000, 32'h0000_0001, w);
    send(32'hFF80_0000, 32'h0000_0002, w);
    n_cmp++; if (data_out[0] !== EXP_NEG || data_out[1] !== 32'h0000_0002) begin n_bad++;
      $display("FAIL negative: got %h %h want %h 00000002", data_out[0], data_out[1], EXP_NEG); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int w;
    ready_out = 1'b0;
    send(32'h0300_0000, 32'h0000_0005, w);
    send(32'h0100_0000, 32'h0000_0007, w);
    valid_in = 2'b11; data_in[0] = 32'h0200_0000; data_in[1] = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (ready_in !== 1'b0 || valid_out !== 2'b11 || data_out[0] !== 32'h0300_0000) begin n_bad++;
        $display("FAIL bp_hold: got ready %b valid %b data %h want 0 11 03000000", ready_in, valid_out, data_out[0]); end
    end
    @(posedge clk); #1;
    ready_out = 1'b1;
    send(32'h0200_0000, 32'hFFFF_0000, w);
    send(32'h0500_0000, 32'hFFF0_0000, w);
    n_cmp++; if (valid_out !== 2'b11 || data_out[0] !== 32'h0500_0000) begin n_bad++;
      $display("FAIL bp_window2: got %b %h want 11 05000000", valid_out, data_out[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int w;
    logic [31:0] a0, a1;
    ready_out = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a0 = $urandom; a1 = $urandom;
      send(a0, a1, w);
      n_cmp++; if (w != 0) begin n_bad++; $display("FAIL stream_stall: got %0d wait cycles want 0", w); end
      n_cmp++; if (valid_out[0] !== (i % 2 == 0)) begin n_bad++;
        $display("FAIL stream_valid: accept %0d got %b want %b", i, valid_out[0], (i % 2 == 0)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_reset();
    int w;
    valid_in = 2'b01; data_in[0] = 32'h7FFF_FFFF; data_in[1] = 32'h7FFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (ready_in !== 1'b1 || valid_out !== 2'b00) begin n_bad++;
        $display("FAIL partial_idle: got ready %b valid %b want 1 00", ready_in, valid_out); end
    end
    @(posedge clk); #1 valid_in = '0;
    send(32'h0000_0010, 32'hFFFF_FFF0, w);
    send(32'h0000_0020, 32'hFFFF_FFE0, w);
    n_cmp++; if (valid_out !== 2'b11 || data_out[0] !== 32'h0000_0020) begin n_bad++;
      $display("FAIL partial_align: got %b %h want 11 00000020", valid_out, data_out[0]); end
    @(posedge clk); #1;
    send(32'h7FFF_0000, 32'h7FFF_0000, w);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (valid_out !== 2'b00 || data_out[0] !== 32'h0 || data_out[1] !== 32'h0) begin n_bad++;
      $display("FAIL async_reset: got %b %h %h want 00 0 0", valid_out, data_out[1], data_out[0]); end
    m_cnt = 0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(32'h0000_0003, 32'h0000_0009, w);
    send(32'h0000_0001, 32'hFFFF_FFFF, w);
    n_cmp++; if (data_out[0] !== 32'h0000_0003 || data_out[1] !== 32'h0000_0009) begin n_bad++;
      $display("FAIL fresh_window: got %h %h want 00000009 00000003", data_out[1], data_out[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_pool1();
    logic [31:0] v0 [0:3];
    logic [31:0] v1 [0:3];
    v0 = '{32'h0123_4567, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    v1 = '{32'h7FFF_FFFF, 32'h0100_0000, 32'h8000_0001, 32'h0000_0042};
    ready_out1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_in1 = 2'b11; data_in1[0] = v0[i]; data_in1[1] = v1[i];
      @(negedge clk);
      n_cmp++; if (ready_in1 !== 1'b1) begin n_bad++; $display("FAIL p1_ready: got %b want 1", ready_in1); end
      @(posedge clk);
      q1.push_back({relu(v1[i]), relu(v0[i])});
      #1;
      n_cmp++; if (valid_out1 !== 2'b11 || data_out1[0] !== relu(v0[i]) || data_out1[1] !== relu(v1[i])) begin
        n_bad++; $display("FAIL p1_pass: got %b %h %h want 11 %h %h",
                          valid_out1, data_out1[1], data_out1[0], relu(v1[i]), relu(v0[i])); end
    end
    valid_in1 = '0;
    @(posedge clk); #1;
    n_cmp++; if (valid_out1 !== 2'b00) begin n_bad++; $display("FAIL p1_drain: got %b want 00", valid_out1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_back_to_back();
    test_partial_reset();
    test_pool1();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (q.size() != 0 || q1.size() != 0) begin n_bad++;
      $display("FAIL sb_drained: got %0d and %0d pending want 0 and 0", q.size(), q1.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
